test_cycle_sequencer: RTL and testbench

Sequences a bank of double-buffered formatter channels (FF_DB_REG instances) through a programmed run of test cycles. It pulls one vector per test cycle from an upstream vector source over a valid/ready handshake and drives the load and transfer strobes for each channel. Each new vector becomes active exactly on a test-cycle boundary, while the formatter enable (EN_FF_LOGIC) stays asserted for the run. The block sits between the vector memory/FIFO and the channel bank; all channels share its strobes.

---
 rtl/test_cycle_sequencer_pkg.sv | 21 ++
 rtl/test_cycle_phase_counter.sv | 38 +++
 rtl/test_cycle_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_test_cycle_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_cycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package : asic_tester_pkg
// Shared types and widths for the test-cycle sequencer.
// Rev     : 1.0
// ============================================================================
package asic_tester_pkg;

    localparam int CYC_W     = 10;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME  = 3'd1,
        S_ARM    = 3'd2,
        S_RUN    = 3'd3,
        S_FINISH = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/test_cycle_phase_counter.sv
`default_nettype none
// ============================================================================
// Module : test_cycle_phase_counter
// Clock-within-test-cycle counter, 0..L-1 with wrap, plus last-phase flag.
// Rev    : 1.0
// ============================================================================
module test_cycle_phase_counter
    import asic_tester_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [CYC_W-1:0] i_len,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CYC_W-1:0] o_phase,
    output logic             o_last_phase
);

    logic [CYC_W-1:0] r_phase;
    logic             w_last;

    assign w_last = (r_phase == (i_len - CYC_W'(1)));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phase <= '0;
        end else if (i_clear) begin
            r_phase <= '0;
        end else if (i_enable) begin
            r_phase <= w_last ? '0 : (r_phase + CYC_W'(1));
        end
    end

    assign o_phase      = r_phase;
    assign o_last_phase = w_last;

endmodule
`default_nettype wire

// File: rtl/test_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module : test_cycle_sequencer
// Feeds one vector per test cycle into a double-buffered formatter bank.
// Rev    : 1.0
// ============================================================================
module test_cycle_sequencer
    import asic_tester_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [CNT_W-1:0] i_num_cycles,
    input  logic [CYC_W-1:0] i_cycle_length,
    input  logic             i_vec_valid,
    output logic             o_vec_ready,
    input  logic [WIDTH-1:0] i_vec_d,
    input  logic [WIDTH-1:0] i_vec_ff,
    input  logic             i_vec_tc,
    output logic [WIDTH-1:0] o_sig_d,
    output logic [WIDTH-1:0] o_sig_ff,
    output logic             o_load_sig,
    output logic             o_load_ff,
    output logic             o_transfer_sig,
    output logic             o_transfer_ff,
    output logic             o_test_cycle,
    output logic             o_en_ff_logic,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_underrun,
    output logic             o_cfg_err,
    output logic [CNT_W-1:0] o_cycle_idx
);

    seq_state_t       r_state;
    seq_state_t       w_next_state;

    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_cycle_idx;
    logic [CYC_W-1:0] r_len;
    logic [WIDTH-1:0] r_sig_d;
    logic [WIDTH-1:0] r_sig_ff;
    logic             r_buf_free;
    logic             r_stop_req;
    logic             r_pend_tc;
    logic             r_test_cycle;
    logic             r_underrun;
    logic             r_cfg_err;

    logic             w_cfg_ok;
    logic             w_start_ok;
    logic             w_last_cycle;
    logic             w_vec_ready;
    logic             w_accept;
    logic             w_transfer;
    logic             w_underrun_evt;
    logic             w_phase_clear;
    logic             w_phase_en;
    logic [CYC_W-1:0] w_phase;
    logic             w_last_phase;

    assign w_cfg_ok      = (i_cycle_length >= CYC_W'(2)) && (i_num_cycles != '0);
    assign w_start_ok    = (r_state == S_IDLE) && i_start && w_cfg_ok;
    assign w_last_cycle  = (r_cycle_idx == (r_num - CNT_W'(1)));
    assign w_accept      = w_vec_ready && i_vec_valid;
    assign w_phase_clear = (r_state != S_RUN);
    assign w_phase_en    = (r_state == S_RUN);

    test_cycle_phase_counter u_phase (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_len        (r_len),
        .i_clear      (w_phase_clear),
        .i_enable     (w_phase_en),
        .o_phase      (w_phase),
        .o_last_phase (w_last_phase)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_vec_ready    = 1'b0;
        w_transfer     = 1'b0;
        w_underrun_evt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next_state = S_PRIME;
            end
            S_PRIME: begin
                w_vec_ready = 1'b1;
                if (i_vec_valid) w_next_state = S_ARM;
            end
            S_ARM: begin
                w_transfer   = 1'b1;
                w_next_state = S_RUN;
            end
            S_RUN: begin
                // Loading is blocked on the boundary clock so it never meets a transfer
                w_vec_ready = r_buf_free && (w_phase != (r_len - CYC_W'(1))) &&
                              !w_last_cycle && !r_stop_req;
                if (w_last_phase) begin
                    if (w_last_cycle || r_stop_req) begin
                        w_next_state = S_FINISH;
                    end else if (!r_buf_free) begin
                        w_transfer = 1'b1;
                    end else begin
                        w_underrun_evt = 1'b1;
                        w_next_state   = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_num        <= '0;
            r_len        <= '0;
            r_cycle_idx  <= '0;
            r_sig_d      <= '0;
            r_sig_ff     <= '0;
            r_buf_free   <= 1'b0;
            r_stop_req   <= 1'b0;
            r_pend_tc    <= 1'b0;
            r_test_cycle <= 1'b0;
            r_underrun   <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= (r_state == S_IDLE) && i_start && !w_cfg_ok;

            if (w_start_ok) begin
                r_num      <= i_num_cycles;
                r_len      <= i_cycle_length;
                r_underrun <= 1'b0;
            end else if (w_underrun_evt) begin
                r_underrun <= 1'b1;
            end

            if (w_accept) begin
                r_sig_d   <= i_vec_d;
                r_sig_ff  <= i_vec_ff;
                r_pend_tc <= i_vec_tc;
            end

            if (w_transfer) begin
                r_test_cycle <= r_pend_tc;
                r_buf_free   <= 1'b1;
            end else if (w_accept) begin
                r_buf_free   <= 1'b0;
            end

            if (r_state == S_ARM) begin
                r_cycle_idx <= '0;
            end else if (w_transfer) begin
                r_cycle_idx <= r_cycle_idx + CNT_W'(1);
            end

            if ((r_state == S_RUN) && i_stop) begin
                r_stop_req <= 1'b1;
            end else if (r_state == S_FINISH) begin
                r_stop_req <= 1'b0;
            end
        end
    end

    assign o_vec_ready    = w_vec_ready;
    assign o_load_sig     = w_accept;
    assign o_load_ff      = w_accept;
    assign o_transfer_sig = w_transfer;
    assign o_transfer_ff  = w_transfer;
    assign o_sig_d        = r_sig_d;
    assign o_sig_ff       = r_sig_ff;
    assign o_test_cycle   = r_test_cycle;
    assign o_en_ff_logic  = (r_state == S_RUN);
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_FINISH);
    assign o_underrun     = r_underrun;
    assign o_cfg_err      = r_cfg_err;
    assign o_cycle_idx    = r_cycle_idx;

endmodule
`default_nettype wire

// File: tb/tb_test_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_test_cycle_sequencer
// Self-checking bench: per-clock schedule predicted from run parameters.
// Rev    : 1.0
// ============================================================================
module tb_test_cycle_sequencer;

    localparam int c_W    = 16;
    localparam int c_CW   = 16;
    localparam int c_MAXV = 15;
    localparam int c_BIG  = 1000000;

    logic            r_clk = 1'b0;
    logic            r_rst_n;
    logic            r_start;
    logic            r_stop;
    logic [c_CW-1:0] r_num;
    logic [9:0]      r_len;
    logic            r_valid;
    logic [c_W-1:0]  r_vec_d;
    logic [c_W-1:0]  r_vec_ff;
    logic            r_vec_tc;

    logic            w_ready, w_load_sig, w_load_ff, w_xfer_sig, w_xfer_ff;
    logic            w_tc, w_en, w_busy, w_done, w_und, w_cfg_err;
    logic [c_W-1:0]  w_sig_d, w_sig_ff;
    logic [c_CW-1:0] w_idx;

    int n_checks = 0;
    int n_pass   = 0;

    // Bench-side memory of what the DUT should be holding between runs
    logic            prev_und = 1'b0;
    logic            prev_tc  = 1'b0;
    int              prev_idx = 0;
    logic [c_W-1:0]  exp_sd   = '0;
    logic [c_W-1:0]  exp_sf   = '0;

    always #5 r_clk = ~r_clk;

    test_cycle_sequencer #(.WIDTH(c_W), .CNT_W(c_CW)) u_dut (
        .i_clk          (r_clk),
        .i_rst_n        (r_rst_n),
        .i_start        (r_start),
        .i_stop         (r_stop),
        .i_num_cycles   (r_num),
        .i_cycle_length (r_len),
        .i_vec_valid    (r_valid),
        .o_vec_ready    (w_ready),
        .i_vec_d        (r_vec_d),
        .i_vec_ff       (r_vec_ff),
        .i_vec_tc       (r_vec_tc),
        .o_sig_d        (w_sig_d),
        .o_sig_ff       (w_sig_ff),
        .o_load_sig     (w_load_sig),
        .o_load_ff      (w_load_ff),
        .o_transfer_sig (w_xfer_sig),
        .o_transfer_ff  (w_xfer_ff),
        .o_test_cycle   (w_tc),
        .o_en_ff_logic  (w_en),
        .o_busy         (w_busy),
        .o_done         (w_done),
        .o_underrun     (w_und),
        .o_cfg_err      (w_cfg_err),
        .o_cycle_idx    (w_idx)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [10:0] flags_now();
        return {w_ready, w_load_sig, w_load_ff, w_xfer_sig, w_xfer_ff,
                w_en, w_busy, w_done, w_und, w_cfg_err, w_tc};
    endfunction

    // START with an illegal configuration: one CFG_ERR pulse, nothing else moves
    task automatic cfg_reject(input int n, input int l);
        logic [10:0] fexp;
        for (int t = 0; t < 3; t++) begin
            @(negedge r_clk);
            r_start = (t == 0);
            r_stop  = 1'b0;
            r_valid = 1'b0;
            r_num   = c_CW'(n);
            r_len   = 10'(l);
            #1;
            fexp = {9'b0, 2'b00};
            fexp[2] = prev_und;
            fexp[1] = (t == 1);
            fexp[0] = prev_tc;
            check_eq("cfg_flags", flags_now(), fexp);
            check_eq("cfg_idx", w_idx, prev_idx);
        end
    endtask

    // One run. Period t = 0 is the clock carrying START. dmax bounds the random
    // delay (in phases) before each vector is offered; a delay of L-1 or a
    // starved vector index produces an underrun.
    task automatic run_seq(input int n, input int l, input int dmax, input bit walk,
                           input int stop_cyc, input int stop_ph, input int starve_k,
                           input int rst_cyc, input int rst_ph);
        int             pv [0:c_MAXV];
        int             lp [0:c_MAXV];
        logic [c_W-1:0] vd [0:c_MAXV];
        logic [c_W-1:0] vf [0:c_MAXV];
        logic           vt [0:c_MAXV];
        int  a, r0, ps, pr, k_end, fin, last, cur, en_cnt, cyc, ph, cc, d;
        bit  und, v, ld, rdy, xf, in_run, in_rst;
        logic [10:0]    fexp;
        int             idx_e;
        logic           tc_e, und_e;

        for (int j = 0; j <= c_MAXV; j++) begin
            pv[j] = c_BIG;
            lp[j] = -1;
            vd[j] = walk ? c_W'(1 << j) : c_W'($urandom);
            vf[j] = c_W'($urandom);
            vt[j] = walk ? 1'(j % 2) : 1'($urandom);
        end

        a  = 1 + int'($urandom_range(dmax));
        pv[0] = a;
        lp[0] = a;
        r0 = a + 2;
        ps = (stop_cyc >= 0) ? r0 + stop_cyc * l + stop_ph : c_BIG;
        pr = (rst_cyc  >= 0) ? r0 + rst_cyc  * l + rst_ph  : c_BIG;
        k_end = n - 1;
        und   = 1'b0;
        for (int k = 0; k < n - 1; k++) begin
            d = int'($urandom_range(dmax));
            if (k + 1 != starve_k) begin
                pv[k+1] = r0 + k * l + d;
                if (d <= l - 2 && pv[k+1] <= ps) lp[k+1] = pv[k+1];
            end
            if (ps < r0 + k * l + l - 1) begin k_end = k; break; end
            if (lp[k+1] < 0) begin k_end = k; und = 1'b1; break; end
        end
        fin  = r0 + (k_end + 1) * l;
        last = (pr < c_BIG) ? pr + 3 : fin + 1;

        cur    = 0;
        en_cnt = 0;
        for (int t = 0; t <= last; t++) begin
            @(negedge r_clk);
            in_rst   = (t > pr);
            v        = (t >= pv[cur]) && (t <= fin) && (t <= pr);
            r_rst_n  = !(t >= pr && t <= pr + 2);
            r_start  = (t == 0);
            r_stop   = (t == ps);
            r_num    = c_CW'(n);
            r_len    = 10'(l);
            r_valid  = v;
            r_vec_d  = vd[cur];
            r_vec_ff = vf[cur];
            r_vec_tc = vt[cur];
            #1;

            in_run = (t >= r0) && (t < fin);
            cyc    = in_run ? (t - r0) / l : 0;
            ph     = in_run ? (t - r0) % l : 0;
            ld     = v && (t == lp[cur]);
            rdy    = (t >= 1 && t <= a) ||
                     (in_run && ph != l - 1 && cyc != n - 1 && t <= ps &&
                      (lp[cyc+1] < 0 || lp[cyc+1] >= t));
            xf     = (t == a + 1) || (in_run && ph == l - 1 && cyc < k_end);
            if (t >= r0) begin
                cc    = ((t - r0) / l > k_end) ? k_end : (t - r0) / l;
                idx_e = cc;
                tc_e  = vt[cc];
            end else begin
                idx_e = prev_idx;
                tc_e  = prev_tc;
            end
            und_e = (t == 0) ? prev_und : (und && t >= fin);
            fexp  = {rdy, ld, ld, xf, xf, in_run, (t >= 1 && t <= fin), (t == fin),
                     und_e, 1'b0, tc_e};
            if (in_rst) begin
                check_eq("rst_flags", flags_now(), 0);
                check_eq("rst_sig_d", w_sig_d, 0);
                check_eq("rst_sig_ff", w_sig_ff, 0);
                check_eq("rst_idx", w_idx, 0);
            end else begin
                check_eq("flags", flags_now(), fexp);
                check_eq("sig_d", w_sig_d, exp_sd);
                check_eq("sig_ff", w_sig_ff, exp_sf);
                check_eq("cycle_idx", w_idx, idx_e);
            end
            en_cnt += int'(w_en);
            if (ld) begin
                exp_sd = vd[cur];
                exp_sf = vf[cur];
                cur++;
            end
        end

        if (pr == c_BIG) begin
            check_eq("en_len", en_cnt, (k_end + 1) * l);
            prev_und = und;
            prev_idx = k_end;
            prev_tc  = vt[k_end];
        end else begin
            prev_und = 1'b0;
            prev_idx = 0;
            prev_tc  = 1'b0;
            exp_sd   = '0;
            exp_sf   = '0;
        end
    endtask

    initial begin
        int n, l, sc, sp;
        r_rst_n  = 1'b0;
        r_start  = 1'b0;
        r_stop   = 1'b0;
        r_num    = '0;
        r_len    = '0;
        r_valid  = 1'b0;
        r_vec_d  = '0;
        r_vec_ff = '0;
        r_vec_tc = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge r_clk);
            #1;
            check_eq("reset_flags", flags_now(), 0);
            check_eq("reset_sig_d", w_sig_d, 0);
            check_eq("reset_idx", w_idx, 0);
        end
        @(negedge r_clk);
        r_rst_n = 1'b1;

        cfg_reject(3, 1);
        cfg_reject(0, 4);
        cfg_reject(2, 0);

        run_seq(3, 4, 0, 1'b1, -1, -1, -1, -1, -1);
        run_seq(3, 5, 0, 1'b1, -1, -1, -1, -1, -1);
        run_seq(4, 3, 0, 1'b0, -1, -1,  2, -1, -1);
        cfg_reject(5, 1);
        run_seq(10, 8, 2, 1'b0, 3, 2, -1, -1, -1);
        run_seq(5, 4, 1, 1'b0, -1, -1, -1, 2, 1);
        run_seq(3, 4, 0, 1'b1, -1, -1, -1, -1, -1);
        run_seq(1, 2, 0, 1'b0, -1, -1, -1, -1, -1);

        for (int r = 0; r < 24; r++) begin
            n  = 1 + int'($urandom_range(7));
            l  = 2 + int'($urandom_range(7));
            sc = ($urandom_range(3) == 0) ? int'($urandom_range(n - 1)) : -1;
            sp = int'($urandom_range(l - 1));
            run_seq(n, l, int'($urandom_range(l - 1)), 1'b0, sc, sp, -1, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
